// File: rtl/data_mem_ctrl.sv
// Data-memory access unit between the single-cycle MIPS datapath and a variable-latency
// word RAM: req/ack handshake, core stall, and error flagging for bad or timed-out accesses.
module data_mem_ctrl #(
    parameter int RAM_AW  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_dout,
    output logic [31:0]       mem_din,
    output logic              mem_stall,
    output logic              mem_err,
    output logic              ram_req,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_cnt;
    logic [7:0]          w_cnt_next;
    logic                r_req;
    logic                w_req_next;
    logic                r_we;
    logic                w_we_next;
    logic [RAM_AW-1:0]   r_addr;
    logic [RAM_AW-1:0]   w_addr_next;
    logic [31:0]         r_wdata;
    logic [31:0]         w_wdata_next;
    logic [31:0]         r_din;
    logic [31:0]         w_din_next;
    logic                r_err;
    logic                w_err_next;

    logic                w_access;
    logic                w_bad;
    logic                w_misaligned;
    logic                w_out_of_range;
    logic                w_conflict;

    // An access is rejected before touching the RAM if it is ambiguous, unaligned or
    // addresses beyond the RAM's word range.
    assign w_access       = cpu_en & (mem_ren | mem_wen);
    assign w_conflict     = mem_ren & mem_wen;
    assign w_misaligned   = (mem_addr[1:0] != 2'b00);
    assign w_out_of_range = (mem_addr[31:RAM_AW+2] != '0);
    assign w_bad          = w_conflict | w_misaligned | w_out_of_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_din   <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_req   <= w_req_next;
            r_we    <= w_we_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_din   <= w_din_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_req_next   = r_req;
        w_we_next    = r_we;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_din_next   = r_din;
        w_err_next   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (w_bad) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_addr_next  = mem_addr[RAM_AW+1:2];
                        w_we_next    = mem_wen;
                        w_wdata_next = mem_dout;
                        w_req_next   = 1'b1;
                        w_cnt_next   = 8'd0;
                        w_state_next = BUSY;
                    end
                end
            end

            BUSY: begin
                // An ack arriving in the last allowed cycle still wins over the timeout.
                if (ram_ack) begin
                    w_req_next   = 1'b0;
                    w_state_next = DONE;
                    if (!r_we) begin
                        w_din_next = ram_rdata;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_req_next   = 1'b0;
                    w_err_next   = 1'b1;
                    w_state_next = DONE;
                    if (!r_we) begin
                        w_din_next = 32'd0;
                    end
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end

            DONE: begin
                if (cpu_en) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // DONE does not stall, so the datapath retires the instruction on the DONE edge.
    assign mem_stall = ((r_state == IDLE) & w_access & ~w_bad) | (r_state == BUSY);

    assign mem_din   = r_din;
    assign mem_err   = r_err;
    assign ram_req   = r_req;
    assign ram_we    = r_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed vector table, hand-written multi-cycle
// sequences (reset mid-access, cpu_en gating) and random accesses against a behavioural model.
module tb_data_mem_ctrl;

    localparam int RAM_AW  = 10;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_en;
    logic              mem_ren;
    logic              mem_wen;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_dout;
    logic [31:0]       mem_din;
    logic              mem_stall;
    logic              mem_err;
    logic              ram_req;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              ram_ack;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram_mem [1024];
    logic [31:0] ref_mem [int];
    logic [31:0] ref_din;

    data_mem_ctrl #(.RAM_AW(RAM_AW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_en    (cpu_en),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_stall (mem_stall),
        .mem_err   (mem_err),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] init_val(input int idx);
        return 32'h9E3779B9 * 32'(idx + 1);
    endfunction

    function automatic logic [31:0] ref_read(input int idx);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return init_val(idx);
    endfunction

    // Behavioural model: outcome of one access given how many wait cycles the RAM takes.
    function automatic void model(input logic ren, input logic wen, input logic [31:0] addr,
                                  input logic [31:0] wdata, input int delay,
                                  output int e_stall, output int e_req, output int e_err);
        bit is_bad;
        int idx;
        is_bad = (ren && wen) || (addr % 4 != 0) || (addr >= 32'h1000);
        idx = int'(addr / 4);
        e_stall = 0; e_req = 0; e_err = 0;
        if (!ren && !wen) return;
        if (is_bad) begin
            e_err = 1;
        end else if (delay < TIMEOUT) begin
            e_req = delay + 1;
            e_stall = delay + 2;
            if (ren) ref_din = ref_read(idx);
            else ref_mem[idx] = wdata;
        end else begin
            e_req = TIMEOUT;
            e_stall = TIMEOUT + 1;
            e_err = 1;
            if (ren) ref_din = 32'd0;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drives one access, plays the RAM with the given ack delay (NEVER = no ack), and
    // reports what was observed up to one cycle after the instruction retired.
    task automatic run_txn(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input int delay,
                           output int n_stall, output int n_req, output int n_err,
                           output logic [31:0] din_out, output logic [31:0] addr_seen,
                           output logic we_seen, output logic [31:0] wdata_seen,
                           output bit stable, output bit hung);
        n_stall = 0; n_req = 0; n_err = 0; stable = 1; hung = 1;
        addr_seen = 0; we_seen = 0; wdata_seen = 0; din_out = 0;
        @(negedge clk);
        cpu_en = 1; mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = wdata; ram_ack = 0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (mem_err) n_err++;
            if (!mem_stall) begin
                if (ram_req) n_req++;
                din_out = mem_din;
                hung = 0;
                break;
            end
            n_stall++;
            ram_ack = 0;
            ram_rdata = $urandom;
            if (ram_req) begin
                if (n_req == 0) begin
                    addr_seen = 32'(ram_addr); we_seen = ram_we; wdata_seen = ram_wdata;
                end else if (addr_seen != 32'(ram_addr) || we_seen != ram_we || wdata_seen != ram_wdata) begin
                    stable = 0;
                end
                n_req++;
                if (n_req == delay + 1) begin
                    ram_ack = 1;
                    if (ram_we) ram_mem[ram_addr] = ram_wdata;
                    else ram_rdata = ram_mem[ram_addr];
                end
            end
            @(negedge clk);
        end
        ram_ack = 0;
        @(negedge clk);
        mem_ren = 0; mem_wen = 0;
        #1;
        if (mem_err) n_err++;
    endtask

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        int          e_stall;
        int          e_req;
        int          e_err;
        logic [31:0] e_din;
        logic [31:0] e_addr;
        logic        e_we;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int n_stall, n_req, n_err, m_stall, m_req, m_err;
        logic [31:0] din_out, addr_seen, wdata_seen;
        logic we_seen;
        bit stable, hung, flag;
        string nm;

        for (int i = 0; i < 1024; i++) ram_mem[i] = init_val(i);
        ram_mem[4] = 32'hCAFEBABE;
        ref_mem[4] = 32'hCAFEBABE;
        ref_din = 32'd0;

        vecs[0]  = '{1, 0, 32'h10,   32'h0,        0,     2,  1,  0, 32'hCAFEBABE,  32'h4,   0};
        vecs[1]  = '{0, 1, 32'hFFC,  32'h12345678, 3,     5,  4,  0, 32'hCAFEBABE,  32'h3FF, 1};
        vecs[2]  = '{1, 0, 32'hFFC,  32'h0,        1,     3,  2,  0, 32'h12345678,  32'h3FF, 0};
        vecs[3]  = '{1, 0, 32'h12,   32'h0,        0,     0,  0,  1, 32'h12345678,  32'h0,   0};
        vecs[4]  = '{1, 0, 32'h1000, 32'h0,        0,     0,  0,  1, 32'h12345678,  32'h0,   0};
        vecs[5]  = '{1, 1, 32'h20,   32'h55,       0,     0,  0,  1, 32'h12345678,  32'h0,   0};
        vecs[6]  = '{0, 1, 32'h40,   32'hDEADBEEF, 0,     2,  1,  0, 32'h12345678,  32'h10,  1};
        vecs[7]  = '{1, 0, 32'h40,   32'h0,        4,     6,  5,  0, 32'hDEADBEEF,  32'h10,  0};
        vecs[8]  = '{1, 0, 32'h80,   32'h0,        14,    16, 15, 0, init_val(32),  32'h20,  0};
        vecs[9]  = '{1, 0, 32'h44,   32'h0,        NEVER, 16, 15, 1, 32'h0,         32'h11,  0};
        vecs[10] = '{0, 1, 32'h44,   32'hAAAA5555, NEVER, 16, 15, 1, 32'h0,         32'h11,  1};
        vecs[11] = '{1, 0, 32'h44,   32'h0,        0,     2,  1,  0, init_val(17),  32'h11,  0};

        rst = 1; cpu_en = 0; mem_ren = 0; mem_wen = 0; mem_addr = 0; mem_dout = 0;
        ram_rdata = 0; ram_ack = 0;
        #3;
        chk("reset ram_req", 32'(ram_req), 0);
        chk("reset ram_we", 32'(ram_we), 0);
        chk("reset ram_addr", 32'(ram_addr), 0);
        chk("reset ram_wdata", ram_wdata, 0);
        chk("reset mem_din", mem_din, 0);
        chk("reset mem_err", 32'(mem_err), 0);
        chk("reset mem_stall", 32'(mem_stall), 0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].delay,
                    n_stall, n_req, n_err, din_out, addr_seen, we_seen, wdata_seen, stable, hung);
            model(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].delay, m_stall, m_req, m_err);
            $display("row %0d ren=%0d wen=%0d addr=%h delay=%0d stall=%0d req=%0d err=%0d din=%h",
                     i, vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].delay, n_stall, n_req, n_err, din_out);
            nm = $sformatf("row%0d", i);
            chk({nm, " hung"}, 32'(hung), 0);
            chk({nm, " stall cycles"}, 32'(n_stall), 32'(vecs[i].e_stall));
            chk({nm, " req cycles"}, 32'(n_req), 32'(vecs[i].e_req));
            chk({nm, " err pulses"}, 32'(n_err), 32'(vecs[i].e_err));
            chk({nm, " mem_din"}, din_out, vecs[i].e_din);
            if (vecs[i].e_req > 0) begin
                chk({nm, " ram_addr"}, addr_seen, vecs[i].e_addr);
                chk({nm, " ram_we"}, 32'(we_seen), 32'(vecs[i].e_we));
                chk({nm, " req stable"}, 32'(stable), 1);
                if (vecs[i].wen) chk({nm, " ram_wdata"}, wdata_seen, vecs[i].wdata);
            end
        end

        // Reset while BUSY with the ack withheld.
        run_txn(1, 0, 32'h10, 0, 0, n_stall, n_req, n_err, din_out, addr_seen, we_seen, wdata_seen, stable, hung);
        model(1, 0, 32'h10, 0, 0, m_stall, m_req, m_err);
        chk("pre-reset read din", din_out, 32'hCAFEBABE);
        @(negedge clk);
        cpu_en = 1; mem_ren = 1; mem_addr = 32'h40; ram_ack = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("busy before reset ram_req", 32'(ram_req), 1);
        #1;
        rst = 1; mem_ren = 0;
        #1;
        $display("reset mid-busy: ram_req=%0d stall=%0d din=%h", ram_req, mem_stall, mem_din);
        chk("async reset ram_req", 32'(ram_req), 0);
        chk("async reset mem_stall", 32'(mem_stall), 0);
        chk("async reset mem_din", mem_din, 0);
        chk("async reset ram_addr", 32'(ram_addr), 0);
        ref_din = 32'd0;
        @(negedge clk);
        rst = 0;
        run_txn(1, 0, 32'h40, 0, 1, n_stall, n_req, n_err, din_out, addr_seen, we_seen, wdata_seen, stable, hung);
        model(1, 0, 32'h40, 0, 1, m_stall, m_req, m_err);
        $display("post-reset read stall=%0d din=%h", n_stall, din_out);
        chk("post-reset stall", 32'(n_stall), 32'(m_stall));
        chk("post-reset din", din_out, ref_din);

        // cpu_en gating: no request while disabled, ack accepted with cpu_en low, DONE held.
        @(negedge clk);
        cpu_en = 0; mem_ren = 1; mem_addr = 32'h10; ram_ack = 0;
        flag = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (ram_req || mem_stall) flag = 1;
            @(negedge clk);
        end
        chk("cpu_en=0 no request", 32'(flag), 0);
        cpu_en = 1;
        #1;
        chk("enable idle stall", 32'(mem_stall), 1);
        @(negedge clk);
        cpu_en = 0;
        #1;
        chk("busy with cpu_en=0 ram_req", 32'(ram_req), 1);
        ram_ack = 1; ram_rdata = ram_mem[ram_addr];
        @(negedge clk);
        ram_ack = 0;
        #1;
        ref_din = ref_read(4);
        chk("ack with cpu_en=0 din", mem_din, ref_din);
        chk("ack with cpu_en=0 stall", 32'(mem_stall), 0);
        repeat (2) @(negedge clk);
        #1;
        chk("held DONE ram_req", 32'(ram_req), 0);
        @(negedge clk);
        cpu_en = 1;
        #1;
        chk("DONE on cpu_en return stall", 32'(mem_stall), 0);
        @(negedge clk);
        #1;
        chk("IDLE after DONE stall", 32'(mem_stall), 1);
        chk("IDLE after DONE ram_req", 32'(ram_req), 0);
        @(negedge clk);
        #1;
        chk("new access ram_req", 32'(ram_req), 1);
        ram_ack = 1; ram_rdata = ram_mem[ram_addr];
        @(negedge clk);
        mem_ren = 0; ram_ack = 0;
        #1;
        chk("new access done din", mem_din, ref_din);
        $display("cpu_en gating sequence done, din=%h", mem_din);

        // Random accesses against the model.
        for (int t = 0; t < 40; t++) begin
            logic r, w;
            logic [31:0] a, d;
            int kind, sel, dly;
            kind = $urandom_range(0, 9);
            sel  = $urandom_range(0, 9);
            r = (kind < 5) || (kind == 9);
            w = (kind >= 5);
            a = {20'h0, 10'($urandom), 2'b00};
            if (sel == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (sel == 1) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
            d = $urandom;
            dly = (sel == 2) ? TIMEOUT + $urandom_range(0, 3) : $urandom_range(0, 6);
            run_txn(r, w, a, d, dly, n_stall, n_req, n_err, din_out, addr_seen, we_seen, wdata_seen, stable, hung);
            model(r, w, a, d, dly, m_stall, m_req, m_err);
            $display("rnd %0d ren=%0d wen=%0d addr=%h delay=%0d stall=%0d req=%0d err=%0d din=%h",
                     t, r, w, a, dly, n_stall, n_req, n_err, din_out);
            nm = $sformatf("rnd%0d", t);
            chk({nm, " hung"}, 32'(hung), 0);
            chk({nm, " stall cycles"}, 32'(n_stall), 32'(m_stall));
            chk({nm, " req cycles"}, 32'(n_req), 32'(m_req));
            chk({nm, " err pulses"}, 32'(n_err), 32'(m_err));
            chk({nm, " mem_din"}, din_out, ref_din);
            if (m_req > 0) begin
                chk({nm, " ram_addr"}, addr_seen, a / 4);
                chk({nm, " req stable"}, 32'(stable), 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory access unit directly downstream of the single-cycle MIPS datapath's memory port. It consumes the datapath's mem_ren, mem_wen, mem_addr and mem_dout. It runs a req/ack handshake to a word-wide data RAM with variable latency, and returns read data on mem_din. It stalls the core through mem_stall until the access completes, and flags misaligned, out-of-range or timed-out accesses on mem_err.

Parameters:
RAM_AW, 10, word-address width of the data RAM (RAM holds 2^RAM_AW words)
TIMEOUT, 15, maximum number of BUSY cycles waited for ram_ack before abort (1..255)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
cpu_en  input  1  cpu enable from debug control
mem_ren  input  1  read request from datapath
mem_wen  input  1  write request from datapath
mem_addr  input  32  byte address from datapath ALU
mem_dout  input  32  store data from datapath (rt)
mem_din  output  32  load data to datapath
mem_stall  output  1  hold PC/regfile write this cycle
mem_err  output  1  one-cycle error pulse
ram_req  output  1  RAM request, held until ack
ram_we  output  1  1 = write, 0 = read
ram_addr  output  RAM_AW  RAM word address
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data, valid with ram_ack
ram_ack  input  1  RAM completion strobe

Behaviour:
- Single clock domain. rst is asynchronous and active-high.
- rst asserted at any time, including mid-transaction:
  - state=IDLE, timeout counter=0.
  - ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, mem_din=0, mem_err=0.
  - Any pending RAM transaction is abandoned.
- Definitions:
  - access = cpu_en & (mem_ren | mem_wen).
  - bad = (mem_ren & mem_wen) | (mem_addr[1:0] != 0) | (mem_addr[31:RAM_AW+2] != 0).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If access & ~bad:
    - latch ram_addr = mem_addr[RAM_AW+1:2], ram_we = mem_wen, ram_wdata = mem_dout;
    - ram_req <= 1, counter <= 0, go to BUSY.
  - If access & bad: no RAM access, stay in IDLE, mem_err <= 1 for one cycle, mem_din unchanged.
- BUSY:
  - ram_req, ram_we, ram_addr and ram_wdata are held stable.
  - On ram_ack=1: ram_req <= 0; if read, mem_din <= ram_rdata; go to DONE.
  - Else counter increments. When counter reaches TIMEOUT-1 with no ack: ram_req <= 0, mem_din <= 0 on a read, mem_err <= 1 for one cycle, go to DONE.
  - cpu_en is ignored in BUSY; the transaction is not abortable except by rst.
- DONE:
  - Go to IDLE when cpu_en=1; otherwise stay in DONE.
- mem_stall (combinational) = (state==IDLE & access & ~bad) | (state==BUSY). It is 0 in DONE, so the datapath retires the instruction at the DONE edge and the next instruction is seen in IDLE.
- mem_din holds the last completed read value. Writes and errors never change it, except a timed-out read, which sets it to 0.
- ram_ack while in IDLE or DONE is ignored.
- Latency: with ack in the first BUSY cycle, the access costs 2 stall cycles (IDLE, BUSY) and data is valid on mem_din in DONE. Each extra wait cycle adds one stall.
- mem_err is registered: it pulses the cycle after a bad access or timeout, and is never high for 2 consecutive cycles from one event.

Test Plan:
- Reset mid-BUSY: read to 0x40 issued, rst pulsed while ram_ack is withheld -> ram_req=0, mem_stall=0, mem_din=0 immediately (async); next access starts cleanly from IDLE.
- Zero-wait read: mem_ren=1, mem_addr=0x0000_0010, RAM acks in the first BUSY cycle with 0xCAFEBABE -> ram_addr=4, mem_stall high for 2 cycles, mem_din=0xCAFEBABE in DONE, no mem_err.
- Write with 3 wait cycles: mem_wen=1, mem_addr=0x0FFC (with RAM_AW=10), mem_dout=0x1234_5678 -> ram_we=1, ram_addr=0x3FF, ram_wdata stable for 4 BUSY cycles, mem_stall for 5 cycles, mem_din unchanged.
- Misaligned, out-of-range and ren+wen: addr 0x0000_0012 read; addr 0x0000_1000 read; ren=wen=1 -> for each, no ram_req, mem_stall=0, one-cycle mem_err pulse.
- Timeout: read with ram_ack tied low, TIMEOUT=15 -> ram_req high exactly 15 cycles, then mem_err pulse, mem_din=0, FSM returns to IDLE.
- cpu_en gating: cpu_en=0 with mem_ren=1 -> no request. cpu_en dropped during BUSY -> ack still accepted. FSM holds DONE until cpu_en returns, then goes to IDLE.
